// File: rtl/mcu_bus_arbiter_if.sv
// Bus bundle between N requesting masters, the arbiter and the shared memory port.
// Handshake: a master raises m_req[i] with stable we/addr/wdata and holds it until m_ack[i] pulses for one cycle.
interface mcu_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0]            m_req;
  logic [NUM_MASTERS-1:0]            m_we;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]            m_ack;
  logic [DATA_WIDTH-1:0]             m_rdata;
  logic                              mem_wr_en;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_data_in;
  logic [DATA_WIDTH-1:0]             mem_data_out;
  logic                              busy;
  logic [IDX_W-1:0]                  grant_id;
  logic [1:0]                        dbg_state;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, mem_data_out,
    output m_ack, m_rdata, mem_wr_en, mem_addr, mem_data_in, busy, grant_id, dbg_state
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, mem_data_out,
    input  m_ack, m_rdata, mem_wr_en, mem_addr, mem_data_in, busy, grant_id, dbg_state
  );
endinterface

// File: rtl/mcu_bus_arbiter.sv
// Round-robin arbiter granting one master at a time onto a single memory port,
// sequencing each access through WAIT_STATES extra cycles and acknowledging with a one-cycle pulse.
module mcu_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  mcu_bus_arbiter_if.slave     bus
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]             r_state;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_grant;
  logic [3:0]             r_wait_cnt;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic                   r_wr_en;
  logic [NUM_MASTERS-1:0] r_ack;

  logic                   w_found;
  logic [IDX_W-1:0]       w_cand;
  logic [IDX_W-1:0]       w_sel;
  logic                   w_sel_we;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic [NUM_MASTERS-1:0] w_grant_oh;

  // Single explicit wrap keeps indices below NUM_MASTERS even for non-power-of-2 counts.
  function automatic int wrap_idx(input int base, input int k);
    int s;
    s = base + k;
    return (s >= NUM_MASTERS) ? s - NUM_MASTERS : s;
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_cand  = '0;
    w_sel   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_cand = IDX_W'(wrap_idx(int'(r_rr_ptr), k));
      if (!w_found && bus.m_req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_sel_we    = bus.m_we[w_sel];
  assign w_sel_addr  = bus.m_addr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_sel_wdata = bus.m_wdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
  assign w_grant_oh  = NUM_MASTERS'(1) << r_grant;

  // The latched address/data registers are the memory port itself, so they hold outside ACCESS.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_wr_en    <= 1'b0;
      r_ack      <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_ack   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state    <= S_ACCESS;
            r_grant    <= w_sel;
            r_we       <= w_sel_we;
            r_addr     <= w_sel_addr;
            r_wdata    <= w_sel_wdata;
            r_wait_cnt <= 4'(WAIT_STATES);
            r_wr_en    <= w_sel_we && (WAIT_STATES == 0);
          end
        end
        S_ACCESS: begin
          if (r_wait_cnt != 4'd0) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            r_wr_en    <= r_we && (r_wait_cnt == 4'd1);
          end else begin
            if (!r_we) r_rdata <= bus.mem_data_out;
            r_ack   <= w_grant_oh;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_rr_ptr <= (r_grant == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_grant + 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.m_ack       = r_ack;
  assign bus.m_rdata     = r_rdata;
  assign bus.mem_wr_en   = r_wr_en;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_data_in = r_wdata;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.grant_id    = r_grant;
  assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_mcu_bus_arbiter.sv
// Scoreboard bench for mcu_bus_arbiter: four instances cover WAIT_STATES 0/1/2/15 and 2 or 3 masters.
module tb_mcu_bus_arbiter;
  localparam int SB_W = 2 + 8 + 32 + 32;
  localparam int WR_W = 2 + 32 + 32 + 32;

  logic clk = 1'b0;
  logic rst_main = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [SB_W-1:0] exp_q[$];
  logic [WR_W-1:0] wr_q[$];
  logic [SB_W-1:0] mon_e;
  logic [WR_W-1:0] mon_w;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  mcu_bus_arbiter_if #(.NUM_MASTERS(2)) ifa ();
  mcu_bus_arbiter_if #(.NUM_MASTERS(3)) ifb ();
  mcu_bus_arbiter_if #(.NUM_MASTERS(2)) ifc ();
  mcu_bus_arbiter_if #(.NUM_MASTERS(2)) ifd ();

  mcu_bus_arbiter #(.NUM_MASTERS(2), .WAIT_STATES(1))  dut_a (.sys_clk(clk), .sys_rst(rst_main), .bus(ifa));
  mcu_bus_arbiter #(.NUM_MASTERS(3), .WAIT_STATES(2))  dut_b (.sys_clk(clk), .sys_rst(rst_b),    .bus(ifb));
  mcu_bus_arbiter #(.NUM_MASTERS(2), .WAIT_STATES(0))  dut_c (.sys_clk(clk), .sys_rst(rst_main), .bus(ifc));
  mcu_bus_arbiter #(.NUM_MASTERS(2), .WAIT_STATES(15)) dut_d (.sys_clk(clk), .sys_rst(rst_main), .bus(ifd));

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory models
  always @(posedge clk) begin
    if (cyc == 0) begin
      mem_a[8'h10] <= 32'hDEADBEEF;
      mem_b[8'h30] <= 32'h33333333;
      mem_b[8'h40] <= 32'h0B0B0040;
      mem_b[8'h44] <= 32'h0B0B0044;
    end
    if (ifa.mem_wr_en) mem_a[ifa.mem_addr[7:0]] <= ifa.mem_data_in;
    if (ifb.mem_wr_en) mem_b[ifb.mem_addr[7:0]] <= ifb.mem_data_in;
  end
  assign ifa.mem_data_out = mem_a[ifa.mem_addr[7:0]];
  assign ifb.mem_data_out = mem_b[ifb.mem_addr[7:0]];
  assign ifc.mem_data_out = 32'hA0000000 | ifc.mem_addr;
  assign ifd.mem_data_out = 32'hA0000000 | ifd.mem_addr;

  // Accessors
  function automatic logic [7:0] ack_of(input int i);
    case (i)
      0: return 8'(ifa.m_ack);
      1: return 8'(ifb.m_ack);
      2: return 8'(ifc.m_ack);
      default: return 8'(ifd.m_ack);
    endcase
  endfunction

  function automatic logic [127:0] out_of(input int i);
    case (i)
      0: return 128'({8'(ifa.m_ack), ifa.m_rdata, ifa.mem_wr_en, ifa.mem_addr, ifa.mem_data_in, ifa.busy, 3'(ifa.grant_id)});
      1: return 128'({8'(ifb.m_ack), ifb.m_rdata, ifb.mem_wr_en, ifb.mem_addr, ifb.mem_data_in, ifb.busy, 3'(ifb.grant_id)});
      2: return 128'({8'(ifc.m_ack), ifc.m_rdata, ifc.mem_wr_en, ifc.mem_addr, ifc.mem_data_in, ifc.busy, 3'(ifc.grant_id)});
      default: return 128'({8'(ifd.m_ack), ifd.m_rdata, ifd.mem_wr_en, ifd.mem_addr, ifd.mem_data_in, ifd.busy, 3'(ifd.grant_id)});
    endcase
  endfunction

  function automatic logic [31:0] rdata_of(input int i);
    case (i)
      0: return ifa.m_rdata;
      1: return ifb.m_rdata;
      2: return ifc.m_rdata;
      default: return ifd.m_rdata;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    case (i)
      0: return ifa.busy;
      1: return ifb.busy;
      2: return ifc.busy;
      default: return ifd.busy;
    endcase
  endfunction

  function automatic logic [64:0] wr_of(input int i);
    case (i)
      0: return {ifa.mem_wr_en, ifa.mem_addr, ifa.mem_data_in};
      1: return {ifb.mem_wr_en, ifb.mem_addr, ifb.mem_data_in};
      2: return {ifc.mem_wr_en, ifc.mem_addr, ifc.mem_data_in};
      default: return {ifd.mem_wr_en, ifd.mem_addr, ifd.mem_data_in};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Driver tasks
  task automatic drive(input int inst, input int m, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit on);
    case (inst)
      0: begin
        ifa.m_req[m[0]] = on; ifa.m_we[m[0]] = we;
        ifa.m_addr[m*32 +: 32] = addr; ifa.m_wdata[m*32 +: 32] = wdata;
      end
      1: begin
        ifb.m_req[m[1:0]] = on; ifb.m_we[m[1:0]] = we;
        ifb.m_addr[m*32 +: 32] = addr; ifb.m_wdata[m*32 +: 32] = wdata;
      end
      2: begin
        ifc.m_req[m[0]] = on; ifc.m_we[m[0]] = we;
        ifc.m_addr[m*32 +: 32] = addr; ifc.m_wdata[m*32 +: 32] = wdata;
      end
      default: begin
        ifd.m_req[m[0]] = on; ifd.m_we[m[0]] = we;
        ifd.m_addr[m*32 +: 32] = addr; ifd.m_wdata[m*32 +: 32] = wdata;
      end
    endcase
  endtask

  task automatic push_exp(input int inst, input logic [7:0] ack, input logic [31:0] rd, input int at);
    exp_q.push_back({2'(inst), ack, rd, 32'(at)});
  endtask

  // One transfer from master m; busy is checked every cycle from the request cycle to the one after ack.
  task automatic xfer(input int inst, input int m, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input int ws);
    int c;
    bit seen;
    logic [7:0] oh;
    @(posedge clk); #1;
    drive(inst, m, we, addr, wdata, 1'b1);
    c  = cyc;
    oh = 8'd1 << m;
    push_exp(inst, oh, exp_rd, c + ws + 2);
    if (we) wr_q.push_back({2'(inst), addr, wdata, 32'(c + ws + 1)});
    seen = 1'b0;
    for (int k = 0; k <= ws + 3; k++) begin
      @(negedge clk);
      chk($sformatf("busy_i%0d_k%0d", inst, k), 128'(busy_of(inst)), 128'(k >= 1 && k <= ws + 2));
      if (ack_of(inst) != 8'd0) seen = 1'b1;
      if (k == ws + 2) drive(inst, m, we, addr, wdata, 1'b0);
    end
    chk($sformatf("ack_seen_i%0d", inst), 128'(seen), 128'(1));
  endtask

  task automatic wait_acks(input int inst, input int n);
    int got;
    got = 0;
    for (int k = 0; k < 80 && got < n; k++) begin
      @(negedge clk);
      if (ack_of(inst) != 8'd0) got++;
    end
    chk($sformatf("ack_count_i%0d", inst), 128'(got), 128'(n));
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ack_of(i) != 8'd0) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_ack: inst %0d ack %b cyc %0d, none expected", i, ack_of(i), cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_tuple{inst,ack,rdata,cyc}", 128'({2'(i), ack_of(i), rdata_of(i), 32'(cyc)}), 128'(mon_e));
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_of(i)[64]) begin
        if (wr_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_wr: inst %0d addr/data %h cyc %0d, none expected", i, wr_of(i)[63:0], cyc);
        end else begin
          mon_w = wr_q.pop_front();
          chk("wr_tuple{inst,addr,data,cyc}", 128'({2'(i), wr_of(i)[63:0], 32'(cyc)}), 128'(mon_w));
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int c;
    ifa.m_req = '0; ifa.m_we = '0; ifa.m_addr = '0; ifa.m_wdata = '0;
    ifb.m_req = '0; ifb.m_we = '0; ifb.m_addr = '0; ifb.m_wdata = '0;
    ifc.m_req = '0; ifc.m_we = '0; ifc.m_addr = '0; ifc.m_wdata = '0;
    ifd.m_req = '0; ifd.m_we = '0; ifd.m_addr = '0; ifd.m_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_main = 1'b0;
    rst_b    = 1'b0;
    for (int i = 0; i < 4; i++) chk($sformatf("reset_outputs_i%0d", i), out_of(i), 128'(0));

    // Instance A: read, write, read-back
    xfer(0, 0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1);
    xfer(0, 1, 1'b1, 32'h20, 32'h12345678, 32'hDEADBEEF, 1);
    xfer(0, 1, 1'b0, 32'h20, 32'h0,        32'h12345678, 1);

    // Instance A: fresh reset, both masters hold requests -> 0,1,0,1
    @(posedge clk); #1;
    rst_main = 1'b1;
    #1;
    chk("reset_async_a", out_of(0), 128'(0));
    @(posedge clk); #1;
    rst_main = 1'b0;
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 32'h10, 32'h0, 1'b1);
    drive(0, 1, 1'b0, 32'h20, 32'h0, 1'b1);
    c = cyc;
    push_exp(0, 8'h01, 32'hDEADBEEF, c + 3);
    push_exp(0, 8'h02, 32'h12345678, c + 7);
    push_exp(0, 8'h01, 32'hDEADBEEF, c + 11);
    push_exp(0, 8'h02, 32'h12345678, c + 15);
    wait_acks(0, 4);
    @(posedge clk); #1;
    drive(0, 0, 1'b0, 32'h10, 32'h0, 1'b0);
    drive(0, 1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Instance B (3 masters): master0 first, then 3'b101 -> grant 2 then wrap to 0
    xfer(1, 0, 1'b0, 32'h40, 32'h0, 32'h0B0B0040, 2);
    @(posedge clk); #1;
    drive(1, 0, 1'b0, 32'h40, 32'h0, 1'b1);
    drive(1, 2, 1'b0, 32'h44, 32'h0, 1'b1);
    c = cyc;
    push_exp(1, 8'h04, 32'h0B0B0044, c + 4);
    push_exp(1, 8'h01, 32'h0B0B0040, c + 9);
    wait_acks(1, 2);
    chk("grant_id_b_after_wrap", 128'(ifb.grant_id), 128'(0));
    @(posedge clk); #1;
    drive(1, 0, 1'b0, 32'h40, 32'h0, 1'b0);
    drive(1, 2, 1'b0, 32'h44, 32'h0, 1'b0);

    // Instance B: reset in cycle 1 of a write drops it
    @(posedge clk); #1;
    drive(1, 1, 1'b1, 32'h30, 32'hBADBAD00, 1'b1);
    @(posedge clk); #1;
    chk("busy_b_before_reset", 128'(ifb.busy), 128'(1));
    rst_b = 1'b1;
    #1;
    chk("reset_mid_write_b", out_of(1), 128'(0));
    drive(1, 1, 1'b1, 32'h30, 32'hBADBAD00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
    xfer(1, 1, 1'b0, 32'h30, 32'h0, 32'h33333333, 2);

    // Instance C: zero wait states, read then write
    xfer(2, 0, 1'b0, 32'h55, 32'h0,        32'hA0000055, 0);
    xfer(2, 1, 1'b1, 32'h66, 32'hCAFEF00D, 32'hA0000055, 0);

    // Instance D: fifteen wait states
    xfer(3, 1, 1'b0, 32'h77, 32'h0, 32'hA0000077, 15);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    chk("wr_q_drained", 128'(wr_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mcu_bus_arbiter.md
# mcu_bus_arbiter

Parametrised multi-master memory arbiter for the second-generation MCU. It sits between N bus masters (CPU instruction/data ports, a future DMA) and the single shared memory port that the v1 MCU drives directly from the CPU. It grants one master at a time using round-robin priority and sequences each access through a configurable number of memory wait states. Each completed transfer is reported with a one-cycle acknowledge.

## Interface
- NUM_MASTERS, 2, number of requesting masters (2..8)
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width
- WAIT_STATES, 1, extra memory cycles per access (0..15)
- IDX_W, $clog2(NUM_MASTERS) (min 1), width of grant_id (localparam)

- sys_clk  in  1  system clock; all state updates on the rising edge
- sys_rst  in  1  reset; asynchronous, active-high
- m_req  in  NUM_MASTERS  per-master request; held until that master's ack
- m_we  in  NUM_MASTERS  per-master write enable (1 = write, 0 = read)
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  master i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  master i write data at [i*DATA_WIDTH +: DATA_WIDTH]
- m_ack  out  NUM_MASTERS  one-hot, one-cycle transfer-complete pulse
- m_rdata  out  DATA_WIDTH  shared read data; valid in the ack cycle, held afterwards
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data_in  out  DATA_WIDTH  memory write data
- mem_data_out  in  DATA_WIDTH  memory read data
- busy  out  1  high in ACCESS and RESP
- grant_id  out  IDX_W  index of the current or last granted master

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If m_req != 0, select the first set bit at or after rr_ptr, scanning cyclically upward with wrap-around.
  - Latch the selected master's index, we, addr and wdata.
  - Load wait_cnt = WAIT_STATES and go to ACCESS.
  - If m_req == 0, stay in IDLE.
- **ACCESS**
  - Drive mem_addr and mem_data_in from the latched values.
  - If wait_cnt != 0, decrement it.
  - If wait_cnt == 0 (final cycle):
    - assert mem_wr_en when the latched we = 1;
    - when the latched we = 0, register mem_data_out into m_rdata at the clock edge;
    - go to RESP.
- **RESP**
  - Pulse m_ack[grant_id] for one cycle.
  - Set rr_ptr = (grant_id + 1) mod NUM_MASTERS; the wrap is explicit and does not depend on a power-of-2 count.
  - Go to IDLE.
- Latched request fields are frozen during ACCESS and RESP. Changes on m_* inputs are ignored.
- Request withdrawal: deasserting m_req during ACCESS does not abort the transfer; the ack still pulses.
- A master still requesting in the IDLE cycle after its ack is treated as a new request at the lowest priority.
- Write transfers leave m_rdata unchanged.
- m_ack bits of non-granted masters are always 0.
- Out-of-range index bits (NUM_MASTERS not a power of 2) are never selected.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, wait_cnt = 0
  - m_ack = 0, m_rdata = 0, mem_wr_en = 0, mem_addr = 0, mem_data_in = 0, busy = 0, grant_id = 0
- Cycle numbering (request seen in IDLE at cycle 0):
  - ACCESS occupies cycles 1..WAIT_STATES+1.
  - mem_wr_en is high only in cycle WAIT_STATES+1.
  - m_ack is high in cycle WAIT_STATES+2.
  - Earliest next grant is in cycle WAIT_STATES+3, giving a throughput of one transfer per WAIT_STATES+3 cycles.
- mem_data_out must be valid in the final ACCESS cycle. Synchronous-read memories require WAIT_STATES >= 1.
- mem_wr_en is registered state-decoded and glitch-free. It is a single-cycle pulse per write.
- Outside ACCESS, mem_addr and mem_data_in hold their last values.
- Reset mid-operation: all outputs return to their reset values asynchronously.
  - An in-flight write with its strobe not yet issued is dropped and no ack is produced.
  - If reset asserts during the write cycle, the strobe is cut asynchronously.

## Test plan
- Read, WAIT_STATES=1: memory[0x10]=0xDEADBEEF; master0 reads 0x10 at cycle 0 -> m_ack[0] pulses at cycle 3, m_rdata=0xDEADBEEF, busy high in cycles 1-3.
- Write then read: master1 writes 0x12345678 to 0x20 -> single mem_wr_en pulse at cycle 2 with mem_addr=0x20, ack[1] at cycle 3; master1 reads 0x20 -> m_rdata=0x12345678.
- Round-robin: after reset, m_req=2'b11 held continuously -> grants in order 0,1,0,1, with acks 4 cycles apart and never both set.
- NUM_MASTERS=3: rr_ptr=1 (after a master0 transfer), m_req=3'b101 -> grant_id=2, m_ack=3'b100; next grant goes to master0 with rr_ptr wrapping 2->0.
- WAIT_STATES=0 and WAIT_STATES=15: single read -> ack at cycle 2 and cycle 17 respectively.
- Reset mid-write: assert sys_rst in cycle 1 of a WAIT_STATES=2 write to 0x30 -> no mem_wr_en pulse, memory[0x30] unchanged, no ack, all outputs 0; after release, a new request is served normally.
